// File: rtl/req_traffic_initiator.sv
// req_traffic_initiator
// Issues a run of NUM_REQ one-cycle request pulses to a responder. Each request is
// preceded by a pseudo-random idle gap taken from an 8-bit LFSR. The block then waits
// for a one-cycle ready pulse and records per-transaction latency, a timeout and
// spurious-ready flags. All outputs come from registers or from decoded registered state.

module req_traffic_initiator #(
    parameter int LFSR_WIDTH = 8,
    parameter int MAX_GAP    = 15,
    parameter int TIMEOUT    = 63,
    parameter int NUM_REQ    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    input  logic                  i_ready,
    output logic                  o_request,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout_err,
    output logic                  o_spurious_err,
    output logic [7:0]            o_req_count,
    output logic [7:0]            o_last_latency,
    output logic [7:0]            o_max_latency
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Modulus for the gap draw, one wider than the LFSR so MAX_GAP+1 = 256 still fits.
    localparam logic [LFSR_WIDTH:0]   GAP_MOD   = (LFSR_WIDTH+1)'(MAX_GAP + 1);
    localparam logic [7:0]            TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [7:0]            LAST_IDX  = 8'(NUM_REQ - 1);
    localparam logic [LFSR_WIDTH-1:0] LFSR_ONE  = LFSR_WIDTH'(1);

    state_t                r_state;
    state_t                w_stateNext;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [LFSR_WIDTH-1:0] r_gapCnt;
    logic [7:0]            r_lat;
    logic [7:0]            r_reqCount;
    logic [7:0]            r_lastLat;
    logic [7:0]            r_maxLat;
    logic                  r_timeoutErr;
    logic                  r_spuriousErr;

    logic [LFSR_WIDTH-1:0] w_lfsrNext;
    logic [LFSR_WIDTH-1:0] w_gapCntNext;
    logic [7:0]            w_latNext;
    logic [7:0]            w_reqCountNext;
    logic [7:0]            w_lastLatNext;
    logic [7:0]            w_maxLatNext;
    logic                  w_timeoutErrNext;
    logic                  w_spuriousErrNext;

    logic [LFSR_WIDTH-1:0] w_seedEff;

    // Fibonacci LFSR step, taps 8/6/5/4; a zero state would lock up, so it is never loaded.
    function automatic logic [LFSR_WIDTH-1:0] lfsrStep(input logic [LFSR_WIDTH-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reduce an LFSR value to an idle gap in the range 0..MAX_GAP.
    function automatic logic [LFSR_WIDTH-1:0] gapOf(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH:0] t;
        t = {1'b0, v} % GAP_MOD;
        return t[LFSR_WIDTH-1:0];
    endfunction

    // A zero seed is replaced by 1 so the LFSR always leaves the all-zero lock-up state.
    assign w_seedEff = (i_seed == '0) ? LFSR_ONE : i_seed;

    // Next-state and datapath update rules; every target holds its value unless a rule fires.
    always_comb begin
        w_stateNext       = r_state;
        w_lfsrNext        = r_lfsr;
        w_gapCntNext      = r_gapCnt;
        w_latNext         = r_lat;
        w_reqCountNext    = r_reqCount;
        w_lastLatNext     = r_lastLat;
        w_maxLatNext      = r_maxLat;
        w_timeoutErrNext  = r_timeoutErr;
        w_spuriousErrNext = r_spuriousErr;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_stateNext       = ST_GAP;
                    w_lfsrNext        = lfsrStep(w_seedEff);
                    w_gapCntNext      = gapOf(w_seedEff);
                    w_reqCountNext    = 8'd0;
                    w_lastLatNext     = 8'd0;
                    w_maxLatNext      = 8'd0;
                    w_timeoutErrNext  = 1'b0;
                    w_spuriousErrNext = 1'b0;
                end
            end

            ST_GAP: begin
                if (i_ready) begin
                    w_spuriousErrNext = 1'b1;
                end
                if (r_gapCnt == '0) begin
                    w_stateNext = ST_REQ;
                end else begin
                    w_gapCntNext = r_gapCnt - LFSR_ONE;
                end
            end

            ST_REQ: begin
                if (i_ready) begin
                    w_spuriousErrNext = 1'b1;
                end
                w_latNext   = 8'd1;
                w_stateNext = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_ready) begin
                    w_reqCountNext = r_reqCount + 8'd1;
                    w_lastLatNext  = r_lat;
                    w_maxLatNext   = (r_lat > r_maxLat) ? r_lat : r_maxLat;
                    if (r_reqCount == LAST_IDX) begin
                        w_stateNext = ST_DONE;
                    end else begin
                        w_gapCntNext = gapOf(r_lfsr);
                        w_lfsrNext   = lfsrStep(r_lfsr);
                        w_stateNext  = ST_GAP;
                    end
                end else if (r_lat == TIMEOUT_L) begin
                    w_timeoutErrNext = 1'b1;
                    w_stateNext      = ST_DONE;
                end else begin
                    w_latNext = r_lat + 8'd1;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE from any state, ahead of start or ready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers: LFSR, gap/latency counters, statistics and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr        <= LFSR_ONE;
            r_gapCnt      <= '0;
            r_lat         <= 8'd0;
            r_reqCount    <= 8'd0;
            r_lastLat     <= 8'd0;
            r_maxLat      <= 8'd0;
            r_timeoutErr  <= 1'b0;
            r_spuriousErr <= 1'b0;
        end else begin
            r_lfsr        <= w_lfsrNext;
            r_gapCnt      <= w_gapCntNext;
            r_lat         <= w_latNext;
            r_reqCount    <= w_reqCountNext;
            r_lastLat     <= w_lastLatNext;
            r_maxLat      <= w_maxLatNext;
            r_timeoutErr  <= w_timeoutErrNext;
            r_spuriousErr <= w_spuriousErrNext;
        end
    end

    assign o_request      = (r_state == ST_REQ);
    assign o_busy         = (r_state == ST_GAP) || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign o_done         = (r_state == ST_DONE);
    assign o_timeout_err  = r_timeoutErr;
    assign o_spurious_err = r_spuriousErr;
    assign o_req_count    = r_reqCount;
    assign o_last_latency = r_lastLat;
    assign o_max_latency  = r_maxLat;

endmodule

// File: tb/tb_req_traffic_initiator.sv
// tb_req_traffic_initiator
// Drives runs of the traffic initiator from a cycle-level schedule computed by a
// transaction model: gaps from the LFSR rule, request = event + gap + 2, ready after a
// chosen latency. Expected request and done observations go into a scoreboard queue,
// and a negedge monitor pops and compares whenever the DUT pulses request or raises done.

module tb_req_traffic_initiator;

    localparam int TB_MAX_GAP = 15;
    localparam int TB_TIMEOUT = 63;
    localparam int TB_NUM_REQ = 16;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_seed;
    logic       i_ready;
    logic       o_request;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout_err;
    logic       o_spurious_err;
    logic [7:0] o_req_count;
    logic [7:0] o_last_latency;
    logic [7:0] o_max_latency;

    req_traffic_initiator #(
        .LFSR_WIDTH(8),
        .MAX_GAP   (TB_MAX_GAP),
        .TIMEOUT   (TB_TIMEOUT),
        .NUM_REQ   (TB_NUM_REQ)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_seed        (i_seed),
        .i_ready       (i_ready),
        .o_request     (o_request),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout_err (o_timeout_err),
        .o_spurious_err(o_spurious_err),
        .o_req_count   (o_req_count),
        .o_last_latency(o_last_latency),
        .o_max_latency (o_max_latency)
    );

    always #5 i_clk = ~i_clk;

    // Cycle index: cycle k is the interval following the k-th rising edge.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit isDone;
        int cyc;
        int reqCount;
        int lastLat;
        int maxLat;
        int tErr;
        int sErr;
    } expect_t;

    expect_t sbQ[$];

    // Per-run stimulus plan: latency 0 means the responder never answers.
    int runLat[TB_NUM_REQ];
    bit runSpur[TB_NUM_REQ];
    bit runStartW[TB_NUM_REQ];
    int runResetAt;

    function automatic void checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endfunction

    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic void pushExp(bit isDone, int c, int cnt, int last, int mx, int te, int se);
        expect_t x;
        x.isDone   = isDone;
        x.cyc      = c;
        x.reqCount = cnt;
        x.lastLat  = last;
        x.maxLat   = mx;
        x.tErr     = te;
        x.sErr     = se;
        sbQ.push_back(x);
    endfunction

    // Monitor: pops one expectation per observed request pulse or rising done.
    function automatic void handleEvent(bit isDone);
        expect_t e;
        string   tag;
        tag = isDone ? "done" : "req";
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_%s actual=event required=none (cycle %0d)", tag, cyc);
            return;
        end
        e = sbQ.pop_front();
        checkOutput({tag, "_kind"}, int'(isDone), int'(e.isDone));
        checkOutput({tag, "_cycle"}, cyc, e.cyc);
        checkOutput({tag, "_req_count"}, int'(o_req_count), e.reqCount);
        checkOutput({tag, "_last_latency"}, int'(o_last_latency), e.lastLat);
        checkOutput({tag, "_max_latency"}, int'(o_max_latency), e.maxLat);
        checkOutput({tag, "_timeout_err"}, int'(o_timeout_err), e.tErr);
        checkOutput({tag, "_spurious_err"}, int'(o_spurious_err), e.sErr);
        checkOutput({tag, "_busy"}, int'(o_busy), isDone ? 0 : 1);
    endfunction

    bit prevDone = 1'b0;
    always @(negedge i_clk) begin
        if (o_request) handleEvent(1'b0);
        if (o_done && !prevDone) handleEvent(1'b1);
        prevDone = o_done;
    end

    task automatic gotoCycle(input int t);
        while (cyc < t) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulseReady(input int t);
        gotoCycle(t);
        i_ready = 1'b1;
        gotoCycle(t + 1);
        i_ready = 1'b0;
    endtask

    task automatic pulseStart(input int t, input logic [7:0] s);
        gotoCycle(t);
        i_seed  = s;
        i_start = 1'b1;
        gotoCycle(t + 1);
        i_start = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been observed.
    task automatic drainScoreboard();
        int w;
        w = 0;
        while (sbQ.size() != 0 && w < 100) begin
            @(posedge i_clk);
            #1;
            w++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d_pending required=0", sbQ.size());
            sbQ.delete();
        end
    endtask

    function automatic void setPlan(int lat);
        for (int i = 0; i < TB_NUM_REQ; i++) begin
            runLat[i]    = lat;
            runSpur[i]   = 1'b0;
            runStartW[i] = 1'b0;
        end
        runResetAt = -1;
    endfunction

    // One run: the transaction model schedules stimulus and queues the expected observations.
    task automatic applyStimulus(input logic [7:0] seed);
        logic [7:0] l;
        int e, p, g, r, lat, cnt, last, mx, sp;
        l    = (seed == 8'h00) ? 8'h01 : seed;
        cnt  = 0;
        last = 0;
        mx   = 0;
        sp   = 0;
        e    = cyc + 2;
        pulseStart(e, seed);
        for (int i = 0; i < TB_NUM_REQ; i++) begin
            g = int'(l) % (TB_MAX_GAP + 1);
            l = lfsrNext(l);
            if (runSpur[i]) sp = 1;
            p = e + g + 2;
            pushExp(1'b0, p, cnt, last, mx, 0, sp);
            if (runSpur[i]) pulseReady(e + 1);
            if (runResetAt == i) begin
                gotoCycle(p + 1);
                checkOutput("pre_reset_req_count", int'(o_req_count), cnt);
                i_reset = 1'b1;
                gotoCycle(p + 2);
                i_reset = 1'b0;
                checkOutput("rst_mid_request", int'(o_request), 0);
                checkOutput("rst_mid_busy", int'(o_busy), 0);
                checkOutput("rst_mid_done", int'(o_done), 0);
                checkOutput("rst_mid_req_count", int'(o_req_count), 0);
                checkOutput("rst_mid_last_latency", int'(o_last_latency), 0);
                checkOutput("rst_mid_max_latency", int'(o_max_latency), 0);
                checkOutput("rst_mid_spurious", int'(o_spurious_err), 0);
                checkOutput("rst_mid_timeout", int'(o_timeout_err), 0);
                pulseReady(p + 3);
                gotoCycle(p + 5);
                checkOutput("post_rst_ready_busy", int'(o_busy), 0);
                checkOutput("post_rst_ready_done", int'(o_done), 0);
                checkOutput("post_rst_ready_req_count", int'(o_req_count), 0);
                checkOutput("post_rst_ready_spurious", int'(o_spurious_err), 0);
                drainScoreboard();
                return;
            end
            lat = runLat[i];
            if (runStartW[i] && lat != 1) pulseStart(p + 1, 8'($urandom));
            if (lat == 0) begin
                pushExp(1'b1, p + TB_TIMEOUT + 1, cnt, last, mx, 1, sp);
                gotoCycle(p + TB_TIMEOUT + 2);
                drainScoreboard();
                return;
            end
            r    = p + lat;
            cnt  = cnt + 1;
            last = lat;
            if (lat > mx) mx = lat;
            if (cnt == TB_NUM_REQ) pushExp(1'b1, r + 1, cnt, last, mx, 0, sp);
            pulseReady(r);
            e = r;
        end
        drainScoreboard();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b0;
        i_seed  = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_request", int'(o_request), 0);
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_done", int'(o_done), 0);
        checkOutput("reset_timeout", int'(o_timeout_err), 0);
        checkOutput("reset_spurious", int'(o_spurious_err), 0);
        checkOutput("reset_req_count", int'(o_req_count), 0);
        checkOutput("reset_last_latency", int'(o_last_latency), 0);
        checkOutput("reset_max_latency", int'(o_max_latency), 0);

        // Reset wins over start and ready in the same cycle.
        i_start = 1'b1;
        i_ready = 1'b1;
        i_seed  = 8'h05;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_ready = 1'b0;
        checkOutput("reset_prio_busy", int'(o_busy), 0);
        checkOutput("reset_prio_spurious", int'(o_spurious_err), 0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("idle_busy", int'(o_busy), 0);

        // Nominal run, responder latency 2.
        setPlan(2);
        applyStimulus(8'h01);

        // Ready while in DONE is ignored.
        pulseReady(cyc + 1);
        gotoCycle(cyc + 1);
        checkOutput("done_ready_spurious", int'(o_spurious_err), 0);
        checkOutput("done_ready_req_count", int'(o_req_count), TB_NUM_REQ);
        checkOutput("done_hold", int'(o_done), 1);

        // Seed 0 behaves as seed 1; start accepted from DONE.
        setPlan(2);
        applyStimulus(8'h00);

        // Mixed latencies 2, 9, 5 and a start ignored during WAIT.
        setPlan(3);
        runLat[0]    = 2;
        runLat[1]    = 9;
        runLat[2]    = 5;
        runStartW[1] = 1'b1;
        runStartW[2] = 1'b1;
        applyStimulus(8'h5A);

        // Ready exactly at the timeout limit completes normally; spurious ready in a gap.
        setPlan(2);
        runLat[0]  = TB_TIMEOUT;
        runSpur[2] = 1'b1;
        applyStimulus(8'hC3);

        // Next start clears the sticky spurious flag; minimum latency throughout.
        setPlan(1);
        applyStimulus(8'h37);

        // Responder never answers the first request.
        setPlan(2);
        runLat[0] = 0;
        applyStimulus(8'h01);

        // Reset in WAIT of the sixth transaction.
        setPlan(4);
        runResetAt = 5;
        applyStimulus(8'h99);

        // Randomised runs.
        for (int k = 0; k < 6; k++) begin
            setPlan(1);
            for (int i = 0; i < TB_NUM_REQ; i++) begin
                runLat[i]    = int'($urandom_range(1, 12));
                runSpur[i]   = ($urandom_range(0, 7) == 0);
                runStartW[i] = ($urandom_range(0, 7) == 0);
            end
            if (k % 3 == 2) runLat[$urandom_range(3, TB_NUM_REQ - 1)] = 0;
            applyStimulus(8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_traffic_initiator.md
REQ_TRAFFIC_INITIATOR -- requirements
Module: req_traffic_initiator

Interface
REQ-001 Parameter LFSR_WIDTH, default 8; width of the gap LFSR and of the seed, fixed at 8 for this revision.
REQ-002 Parameter MAX_GAP, default 15; upper bound of the random idle gap between transactions, in cycles.
REQ-003 Parameter TIMEOUT, default 63; maximum wait for ready, in cycles; legal range 1..255.
REQ-004 Parameter NUM_REQ, default 16; number of transactions per run; legal range 1..255.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  run start strobe.
REQ-008 seed  input  8  gap LFSR seed, sampled on an accepted start.
REQ-009 ready  input  1  one-cycle completion pulse from the responder.
REQ-010 request  output  1  one-cycle transaction request pulse to the responder.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run end until the next accepted start or reset.
REQ-013 timeout_err  output  1  sticky; the run ended on a timeout.
REQ-014 spurious_err  output  1  sticky; ready was seen outside WAIT while busy.
REQ-015 req_count  output  8  number of transactions completed in the current run.
REQ-016 last_latency  output  8  latency of the most recent completed transaction.
REQ-017 max_latency  output  8  largest latency seen in the current run.

Function
REQ-018 The FSM SHALL have the states IDLE, GAP, REQ, WAIT and DONE; busy SHALL equal (state is GAP, REQ or WAIT), and done SHALL equal (state is DONE).
REQ-019 Start acceptance: start SHALL be accepted only in IDLE or DONE; start in GAP, REQ or WAIT SHALL be ignored.
REQ-020 On an accepted start the block SHALL do all of the following, then go to GAP:
- load the LFSR with seed, or with 8'h01 when seed is 0;
- clear req_count, last_latency, max_latency, timeout_err and spurious_err;
- load gap_cnt = (value loaded) mod (MAX_GAP+1);
- advance the LFSR once.
REQ-021 LFSR advance: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; the LFSR SHALL advance only when a new gap is loaded.
REQ-022 GAP state:
- gap_cnt == 0: go to REQ;
- otherwise: decrement gap_cnt and stay in GAP.
REQ-023 REQ state: the state SHALL last exactly one cycle, request SHALL be high in that cycle only, lat SHALL be set to 1, and the next state SHALL be WAIT; request SHALL be low in every other state.
REQ-024 WAIT with ready high: req_count += 1, last_latency <= lat, max_latency <= max(max_latency, lat); then
- if req_count+1 == NUM_REQ: go to DONE;
- otherwise: load gap_cnt = (current lfsr) mod (MAX_GAP+1), advance the LFSR, and go to GAP.
REQ-025 WAIT with ready low:
- lat == TIMEOUT: set timeout_err and go to DONE, with req_count unchanged;
- otherwise: lat += 1.
REQ-026 Ready sampled in the same cycle that lat == TIMEOUT SHALL complete the transaction normally, with no timeout.
REQ-027 Ready high while in GAP or REQ SHALL set spurious_err and SHALL change no other state; ready in IDLE or DONE SHALL be ignored.
REQ-028 Latency meaning: latency is the cycle count from the request cycle to the ready cycle, both inclusive of the edge count; a responder that asserts ready two cycles after request yields latency 2.
REQ-029 Spacing: the minimum spacing from a ready cycle to the next request SHALL be 2 cycles (gap 0); the maximum SHALL be MAX_GAP+2.
REQ-030 In DONE the block SHALL hold all counters and error flags stable until the next accepted start.
REQ-031 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-032 Reset SHALL force, from the first clock edge with reset high and regardless of the current state, including mid-WAIT:
- state IDLE;
- request, busy, done, timeout_err and spurious_err to 0;
- req_count, last_latency, max_latency, lat and gap_cnt to 0;
- lfsr to 8'h01.
REQ-033 Reset SHALL take priority over start and ready sampled in the same cycle.

Verification
REQ-034 Nominal run: seed=8'h01, MAX_GAP=15, bench responder returns ready 2 cycles after each request, NUM_REQ=16 ->
- first request is high on the 3rd cycle after the start cycle;
- after 16 transactions: done=1, req_count=16, last_latency=max_latency=2, both error flags 0.
REQ-035 Timeout: responder never asserts ready, TIMEOUT=63 -> request pulses exactly once, timeout_err=1 and done=1 once lat reaches 63 with ready low, req_count=0.
REQ-036 Latency edges: ready arrives exactly at lat==63 -> normal completion with last_latency=63 and timeout_err=0; mixed latencies 2, 9, 5 -> max_latency=9 and last_latency=5.
REQ-037 Spurious ready: ready pulsed during GAP -> spurious_err=1 and stays 1, req_count unchanged; a subsequent start clears it to 0.
REQ-038 Start handling: start asserted during WAIT -> ignored, the run continues unchanged; start in DONE -> counters clear and a new run begins; seed=0 -> request timing identical to seed=8'h01.
REQ-039 Reset mid-run: reset asserted in WAIT with req_count=5 -> next cycle all outputs 0, state IDLE; a later ready pulse is ignored.
